// File: rtl/counter_bank_pkg.sv
// Shared constants and configuration checks for counter_bank.
// Optional channel cascading is enabled by COUNTER_BANK_CHAIN_EN.
package counter_bank_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  function automatic bit cfg_ok(
    input int unsigned n_ch,
    input int unsigned width
  );
    return (n_ch >= 1) && (n_ch <= MAX_CH) &&
           (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One counter channel: register, adder, wrap/saturate select,
// match detector and qualified carry-out for cascading.
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             gate_i,
  input  logic             sat_mode_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             match_o,
  output logic             match_nxt_o,
  output logic             carry_o
);

  logic [WIDTH:0]   sum;
  logic             upd;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;
  logic             match_d, match_q;

  assign sum     = {1'b0, cnt_q} + {1'b0, step_i};
  assign upd     = en_i & ~clr_i & gate_i;
  assign carry_o = upd & sum[WIDTH];

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (upd) begin
      if (sum[WIDTH] && (sat_mode_i == MODE_SAT)) begin
        cnt_d = '1;
      end else begin
        cnt_d  = sum[WIDTH-1:0];
        wrap_d = sum[WIDTH];
      end
    end
    // A hold at the compare value never re-fires.
    match_d = (cnt_d != cnt_q) && (cnt_d == cmp_val_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign wrap_o      = wrap_q;
  assign match_o     = match_q;
  assign match_nxt_o = match_d;

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH up-counters with sticky match interrupt.
// Define COUNTER_BANK_CHAIN_EN to add chain_en carry cascading.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       sat_mode,
  input  logic [N_CH*WIDTH-1:0] step,
  input  logic [N_CH*WIDTH-1:0] cmp_val,
  input  logic                  irq_ack,
`ifdef COUNTER_BANK_CHAIN_EN
  input  logic [N_CH-1:0]       chain_en,
`endif
  output logic [N_CH*WIDTH-1:0] cnt_out,
  output logic [N_CH-1:0]       wrap_pulse,
  output logic [N_CH-1:0]       match,
  output logic                  irq
);

  if (!cfg_ok(N_CH, WIDTH)) begin : g_bad_cfg
    $error("counter_bank: N_CH or WIDTH out of range");
  end

  logic [N_CH-1:0] gate;
  logic [N_CH-1:0] carry;
  logic [N_CH-1:0] match_nxt;
  logic            irq_d, irq_q;

`ifdef COUNTER_BANK_CHAIN_EN
  // Channel i advances only on a real carry out of channel i-1.
  assign gate[0] = 1'b1;
  for (genvar i = 1; i < N_CH; i++) begin : g_chain
    assign gate[i] = ~chain_en[i] | carry[i-1];
  end
  logic unused_chain;
  assign unused_chain = chain_en[0] ^ carry[N_CH-1];
`else
  assign gate = '1;
  logic unused_carry;
  assign unused_carry = ^carry;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en[i]),
      .clr_i       (clr[i]),
      .gate_i      (gate[i]),
      .sat_mode_i  (sat_mode[i]),
      .step_i      (step[i*WIDTH +: WIDTH]),
      .cmp_val_i   (cmp_val[i*WIDTH +: WIDTH]),
      .cnt_o       (cnt_out[i*WIDTH +: WIDTH]),
      .wrap_o      (wrap_pulse[i]),
      .match_o     (match[i]),
      .match_nxt_o (match_nxt[i]),
      .carry_o     (carry[i])
    );
  end

  always_comb begin
    irq_d = irq_q;
    if (|match_nxt) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_counter_bank.sv
// Randomised and directed bench for counter_bank against a
// behavioural model of the counting rules.
module tb_counter_bank;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned WIDTH = 8;
  localparam longint MAXV = (64'd1 << WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       en, clr, sat_mode;
  logic [N_CH*WIDTH-1:0] step, cmp_val;
  logic                  irq_ack;
  logic [N_CH-1:0]       chain_en;
  logic [N_CH*WIDTH-1:0] cnt_out;
  logic [N_CH-1:0]       wrap_pulse, match;
  logic                  irq;

  counter_bank #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .sat_mode   (sat_mode),
    .step       (step),
    .cmp_val    (cmp_val),
    .irq_ack    (irq_ack),
`ifdef COUNTER_BANK_CHAIN_EN
    .chain_en   (chain_en),
`endif
    .cnt_out    (cnt_out),
    .wrap_pulse (wrap_pulse),
    .match      (match),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  longint          m_cnt [N_CH];
  logic [N_CH-1:0] m_wrap, m_match;
  logic            m_irq;

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_cnt(input int ch);
    return longint'(cnt_out[ch*WIDTH +: WIDTH]);
  endfunction

  task automatic set_step(input int ch, input longint v);
    step[ch*WIDTH +: WIDTH] = v[WIDTH-1:0];
  endtask

  task automatic set_cmp(input int ch, input longint v);
    cmp_val[ch*WIDTH +: WIDTH] = v[WIDTH-1:0];
  endtask

  // Reference: arithmetic on integers, channels in order so a
  // carry from the lower channel is visible to the next.
  task automatic model_step();
    bit     cprev;
    bit     ok;
    longint old, nw, s, st, cv;
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_wrap  = '0;
      m_match = '0;
      m_irq   = 1'b0;
      return;
    end
    m_wrap  = '0;
    m_match = '0;
    cprev   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      old = m_cnt[i];
      st  = longint'(step[i*WIDTH +: WIDTH]);
      cv  = longint'(cmp_val[i*WIDTH +: WIDTH]);
      s   = old + st;
      nw  = old;
      ok  = 1'b1;
`ifdef COUNTER_BANK_CHAIN_EN
      if (i > 0 && chain_en[i]) ok = cprev;
`endif
      cprev = 1'b0;
      if (clr[i]) begin
        nw = 0;
      end else if (en[i] && ok) begin
        if (s > MAXV) begin
          cprev = 1'b1;
          if (sat_mode[i]) begin
            nw = MAXV;
          end else begin
            nw = s - (MAXV + 1);
            m_wrap[i] = 1'b1;
          end
        end else begin
          nw = s;
        end
      end
      if (nw != old && nw == cv) m_match[i] = 1'b1;
      m_cnt[i] = nw;
    end
    if (|m_match) m_irq = 1'b1;
    else if (irq_ack) m_irq = 1'b0;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N_CH; i++)
      check($sformatf("cnt%0d", i), get_cnt(i), m_cnt[i]);
    check("wrap", longint'(wrap_pulse), longint'(m_wrap));
    check("match", longint'(match), longint'(m_match));
    check("irq", longint'(irq), longint'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int pulses;

  initial begin
    rst      = 1'b1;
    en       = '1;
    clr      = '0;
    sat_mode = '0;
    step     = '0;
    cmp_val  = '0;
    irq_ack  = 1'b0;
    chain_en = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_wrap  = '0;
    m_match = '0;
    m_irq   = 1'b0;
    set_step(0, 1);
    set_step(1, 1);

    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_cnt", longint'(cnt_out), 0);
      check("rst_irq", longint'(irq), 0);
    end
    rst = 1'b0;
    en  = '0;
    tick();
    check("rel_cnt", longint'(cnt_out), 0);

    // Wrap on ch0
    set_cmp(0, 128);
    set_cmp(1, 77);
    en = 2'b01;
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (wrap_pulse[0]) pulses++;
      if (k == 255) check("wrap_255", get_cnt(0), 255);
    end
    check("wrap_0", get_cnt(0), 0);
    check("wrap_pl", longint'(wrap_pulse[0]), 1);
    check("wrap_cnt", pulses, 1);

    // Saturate on ch1
    en = 2'b10;
    sat_mode = 2'b10;
    set_step(1, 100);
    set_cmp(1, 255);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sat_wrap", longint'(wrap_pulse[1]), 0);
      if (match[1]) pulses++;
      case (k)
        0: check("sat_v", get_cnt(1), 100);
        1: check("sat_v", get_cnt(1), 200);
        default: check("sat_v", get_cnt(1), 255);
      endcase
    end
    check("sat_match", pulses, 1);
    en = '0;
    irq_ack = 1'b1;
    tick();
    check("ack_irq", longint'(irq), 0);
    irq_ack = 1'b0;

    // Match and irq on ch1
    sat_mode = '0;
    set_cmp(1, 208);
    clr = 2'b10;
    tick();
    clr = '0;
    en = 2'b10;
    set_step(1, 16);
    for (int k = 0; k < 13; k++) tick();
    check("m_cnt", get_cnt(1), 208);
    check("m_pulse", longint'(match[1]), 1);
    check("m_irq", longint'(irq), 1);
    for (int k = 0; k < 15; k++) tick();
    check("m_hold", longint'(irq), 1);
    irq_ack = 1'b1;
    tick();
    check("m2_cnt", get_cnt(1), 208);
    check("m2_irq", longint'(irq), 1);
    en = '0;
    tick();
    check("lone_ack", longint'(irq), 0);
    irq_ack = 1'b0;

    // clr beats en on ch0, then reset mid-run on ch1
    clr = 2'b01;
    tick();
    clr = '0;
    en = 2'b01;
    set_step(0, 50);
    tick();
    check("pri_50", get_cnt(0), 50);
    clr = 2'b01;
    tick();
    check("pri_0", get_cnt(0), 0);
    clr = 2'b10;
    en = '0;
    tick();
    clr = '0;
    en = 2'b10;
    set_step(1, 120);
    set_cmp(1, 240);
    tick();
    check("mr_120", get_cnt(1), 120);
    rst = 1'b1;
    tick();
    check("mr_cnt", longint'(cnt_out), 0);
    check("mr_wrap", longint'(wrap_pulse), 0);
    check("mr_match", longint'(match), 0);
    check("mr_irq", longint'(irq), 0);
    rst = 1'b0;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 63) == 0);
      en       = N_CH'($urandom);
      irq_ack  = ($urandom_range(0, 7) == 0);
      chain_en = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) begin
        clr[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) sat_mode[i] = ~sat_mode[i];
        case ($urandom_range(0, 3))
          0: set_step(i, 0);
          1: set_step(i, $urandom_range(1, 7));
          default: set_step(i, longint'($urandom) & MAXV);
        endcase
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 1) == 0) set_cmp(i, MAXV);
          else set_cmp(i, $urandom_range(0, 31));
        end
      end
      tick();
    end

`ifdef COUNTER_BANK_CHAIN_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    irq_ack = 1'b0;
    clr = '0;
    sat_mode = '0;
    en = '1;
    chain_en = '0;
    chain_en[1] = 1'b1;
    set_step(0, 1);
    set_step(1, 1);
    set_cmp(0, 3);
    set_cmp(1, 3);
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (wrap_pulse[1]) pulses++;
    end
    check("ch_lo", get_cnt(0), 0);
    check("ch_hi", get_cnt(1), 1);
    for (int k = 256; k < 65536; k++) begin
      tick();
      if (wrap_pulse[1]) pulses++;
    end
    check("ch_lo2", get_cnt(0), 0);
    check("ch_hi2", get_cnt(1), 0);
    check("ch_wrap", pulses, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of N_CH independent up-counters, the successor to the fixed two-channel 8-bit counters block. Each channel has its own enable, step, wrap-or-saturate mode and compare value. Each channel emits per-channel wrap and match pulses, and the bank combines match pulses into one sticky interrupt. It sits beside the existing counters in the mixed-language example and is driven from both the Verilog and SystemC benches.

## Interface
- N_CH, 2, number of counter channels (1..16)
- WIDTH, 8, bits per counter (2..32)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  N_CH  per-channel count enable
- clr  in  N_CH  per-channel synchronous clear
- sat_mode  in  N_CH  1 = saturate at all-ones, 0 = wrap modulo 2^WIDTH
- step  in  N_CH*WIDTH  increment; channel i at [i*WIDTH +: WIDTH]
- cmp_val  in  N_CH*WIDTH  compare value, same packing
- irq_ack  in  1  clears irq
- cnt_out  out  N_CH*WIDTH  counter values, same packing
- wrap_pulse  out  N_CH  one-cycle overflow pulse
- match  out  N_CH  one-cycle compare pulse
- irq  out  1  sticky OR of match events

## Operation
- Per-channel priority: rst > clr > en. If clr=1, next count = 0 regardless of en.
- Count update (en=1, clr=0):
  - sum = cnt + step, computed in WIDTH+1 bits; carry = sum[WIDTH].
  - Wrap mode: cnt <= sum[WIDTH-1:0]. wrap_pulse=1 when carry=1.
  - Saturate mode: cnt <= all-ones when carry=1, else sum. wrap_pulse never asserts.
  - step=0: count holds and no pulses.
- match[i]=1 for one cycle when the registered count changes (new != old) and new == cmp_val[i]. A change caused by clr counts as a change.
- Holding at a value equal to cmp_val does not re-pulse. This covers saturation at max, step 0, and en=0.
- irq is set when any match bit is being asserted. It is cleared by irq_ack.
  - If set and ack occur in the same cycle, set wins.
- Changing sat_mode mid-count takes effect on the next update. The count is not altered by the mode change itself.
- Reset mid-operation: every output is 0 on the cycle after the rst edge, and any pending pulses are discarded.

## Timing
- All outputs are registered. Reset value of cnt_out, wrap_pulse, match and irq is 0.
- en, clr and step are sampled at edge k. The new cnt_out, plus wrap_pulse and match for that update, are visible after edge k, in the same cycle as each other.
- irq rises in the same cycle as the causing match pulse. It falls in the cycle after irq_ack is sampled, unless a new match occurs.
- No handshake and no backpressure. Throughput is one update per channel per cycle.

## Configuration
- COUNTER_BANK_CHAIN_EN defined:
  - Adds input chain_en [N_CH-1:0].
  - For i >= 1 with chain_en[i]=1, channel i updates only in cycles where channel i-1 has en=1, clr=0 and carry=1. The carry is taken combinationally within the same cycle, and channel i's own en must also be 1.
  - This cascades channels into a wider counter.
  - chain_en[0] is ignored.
  - A clr on channel i-1 does not clear channel i.
- COUNTER_BANK_CHAIN_EN undefined:
  - chain_en port is absent and all channels are fully independent.
  - No carry path exists between channels.

## Structure
- Package counter_bank_pkg holds:
  - count mode constants: MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - the max-channel and max-width limits
  - a width-check macro/function used by the parameter assertions
- Sub-module counter_bank_channel holds one channel's register, adder, saturate/wrap mux, match detector and carry-out (for chaining). It is instantiated N_CH times in a generate loop.
- The top level holds the irq register, unpacking/packing and chain wiring.

## Test plan
- Reset: hold rst 3 cycles with en=all-ones → cnt_out=0, wrap_pulse=0, match=0, irq=0 throughout and one cycle after release.
- Wrap: ch0 with step=1, wrap mode, 256 enabled cycles from 0 → cnt0 = 255 then 0, with wrap_pulse[0] high only in the cycle cnt0=0.
- Saturate: ch1 with step=100, sat mode → cnt1 = 100, 200, 255, 255. wrap_pulse[1] never asserts and a single match fires when cmp_val=255.
- Match/irq: ch1 with step=16, cmp_val=208 → after 13 updates cnt1=208 with match[1] for one cycle and irq latched. irq_ack in the same cycle as a second match → irq stays 1. A lone ack → irq=0 in the next cycle.
- Priority and mid-run reset: clr=1 with en=1 at cnt0=50 → cnt0=0. rst pulsed at cnt1=120 → every output 0 in the next cycle.
- Chain (macro on): ch0 and ch1 with step=1 and chain_en[1]=1, 256 cycles → ch1=1, ch0=0. After 65536 cycles both are 0 and wrap_pulse[1] pulses once.
